// File: rtl/spi_txn_scheduler_pkg.sv
// Shared definitions for the SPI transaction scheduler: FSM encoding, mode-bit
// indices and the round-robin winner picker.
package spi_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_SETUP = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int unsigned MODE_CPOL = 1;
  localparam int unsigned MODE_CPHA = 0;

  // One-hot winner: first set req bit at or above ptr, wrapping at n (n <= 8).
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input logic [3:0] n);
    logic [7:0] win;
    logic       found;
    logic [3:0] idx;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= n) idx = idx - n;
      if (!found && (4'(k) < n) && req[idx[2:0]]) begin
        win[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/spi_txn_scheduler_if.sv
// Requester-side bus of the SPI transaction scheduler: requests, grants, results.
interface spi_txn_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*2-1:0]  req_mode;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rdata;
  logic               busy;

  modport master (output req, req_data, req_mode, input grant, done, rdata, busy);
  modport slave  (input req, req_data, req_mode, output grant, done, rdata, busy);
endinterface

// File: rtl/spi_txn_scheduler_shift.sv
// SPI shift engine: half-period divider, sclk edge generation and the TX/RX
// shift registers for one DW-bit MSB-first transfer.
module spi_shift_engine #(
  parameter int DW      = 8,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          start,
  input  logic          cpol,
  input  logic          cpha,
  input  logic [DW-1:0] txd,
  input  logic          miso,
  output logic          sclk,
  output logic          mosi,
  output logic [DW-1:0] rxd,
  output logic          finished
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DW);

  logic [DW-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [CW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sclk_q, sclk_d, mosi_q, mosi_d, cpol_q, cpol_d, cpha_q, cpha_d;
  logic          run_q, run_d, fin_q, fin_d;
  logic          lead;

  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    div_d  = div_q;
    bit_d  = bit_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    cpol_d = cpol_q;
    cpha_d = cpha_q;
    run_d  = run_q;
    fin_d  = 1'b0;
    lead   = (sclk_q == cpol_q);
    // cpha=0 presents the MSB before the first edge; cpha=1 drives it on the first leading edge.
    if (load) begin
      cpol_d = cpol;
      cpha_d = cpha;
      sclk_d = cpol;
      rx_d   = '0;
      bit_d  = '0;
      if (cpha) begin
        tx_d   = txd;
        mosi_d = 1'b0;
      end else begin
        tx_d   = {txd[DW-2:0], 1'b0};
        mosi_d = txd[DW-1];
      end
    end
    if (start) begin
      run_d = 1'b1;
      div_d = '0;
    end
    if (run_q) begin
      if (div_q == CW'(CLK_DIV - 1)) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        if (lead != cpha_q) begin
          rx_d = {rx_q[DW-2:0], miso};
        end else begin
          mosi_d = tx_q[DW-1];
          tx_d   = {tx_q[DW-2:0], 1'b0};
        end
        if (!lead) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DW - 1)) begin
            run_d = 1'b0;
            fin_d = 1'b1;
          end
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q   <= '0;
      rx_q   <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      run_q  <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cpol_q <= cpol_d;
      cpha_q <= cpha_d;
      run_q  <= run_d;
      fin_q  <= fin_d;
    end
  end

  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign rxd      = rx_q;
  assign finished = fin_q;

endmodule

// File: rtl/spi_txn_scheduler.sv
// Round-robin scheduler sharing one SPI bus among NREQ requesters.
// Optional SPI_LOOPBACK_EN adds a `loopback` input routing mosi back to the sampler.
module spi_txn_scheduler
  import spi_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_txn_scheduler_if.slave   bus,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic [NREQ-1:0]      ss_n
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic                 loopback
`endif
);
  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      owner_q, owner_d, rr_ptr_q, rr_ptr_d, win_idx;
  logic [DW-1:0]   rdata_q, rdata_d, win_data, eng_rxd;
  logic [7:0]      win8;
  logic [1:0]      win_mode;
  logic            any_req, eng_load, eng_start, eng_sclk, eng_mosi, eng_fin, samp_in;

  assign any_req = |bus.req;
  assign win8    = rr_pick(8'(bus.req), rr_ptr_q, 4'(NREQ));

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    win_mode = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (win8[i]) win_idx = 3'(i);
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == 3'(i)) begin
        win_data = bus.req_data[i*DW +: DW];
        win_mode = bus.req_mode[i*2 +: 2];
      end
    end
  end

`ifdef SPI_LOOPBACK_EN
  logic lb_q, lb_d;
  always_comb lb_d = (state_q == S_ARB) ? loopback : lb_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lb_q <= 1'b0;
    else        lb_q <= lb_d;
  end
  assign samp_in = lb_q ? eng_mosi : miso;
`else
  assign samp_in = miso;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    rdata_d   = rdata_q;
    eng_load  = 1'b0;
    eng_start = 1'b0;
    case (state_q)
      S_IDLE: if (any_req) state_d = S_ARB;
      S_ARB: begin
        if (any_req) begin
          state_d  = S_SETUP;
          cnt_d    = '0;
          grant_d  = win8[NREQ-1:0];
          owner_d  = win_idx;
          eng_load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = S_SHIFT;
          cnt_d     = '0;
          eng_start = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (eng_fin) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      // rdata is captured on HOLD exit so it is already valid while done pulses.
      S_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          rdata_d = eng_rxd;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        grant_d  = '0;
        rr_ptr_d = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  spi_shift_engine #(.DW(DW), .CLK_DIV(CLK_DIV)) u_engine (
    .clk      (clk),
    .reset    (reset),
    .load     (eng_load),
    .start    (eng_start),
    .cpol     (win_mode[MODE_CPOL]),
    .cpha     (win_mode[MODE_CPHA]),
    .txd      (win_data),
    .miso     (samp_in),
    .sclk     (eng_sclk),
    .mosi     (eng_mosi),
    .rxd      (eng_rxd),
    .finished (eng_fin)
  );

  assign bus.grant = grant_q;
  assign bus.done  = (state_q == S_DONE) ? grant_q : '0;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign sclk      = (|grant_q) ? eng_sclk : 1'b0;
  assign mosi      = (state_q == S_SETUP || state_q == S_SHIFT) ? eng_mosi : 1'b0;
  assign ss_n      = (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD) ? ~grant_q : '1;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed self-checking bench for spi_txn_scheduler with a behavioural SPI slave.
module tb_spi_txn_scheduler;
  localparam int NREQ = 4, DW = 8, CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sclk, mosi, miso;
  logic [3:0] ss_n;
`ifdef SPI_LOOPBACK_EN
  logic       loopback = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_txn_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

  spi_txn_scheduler #(.NREQ(NREQ), .DW(DW), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .ss_n  (ss_n)
`ifdef SPI_LOOPBACK_EN
    ,
    .loopback (loopback)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural SPI slave: shifts sl_tx out on miso, captures mosi into sl_rx.
  logic [7:0] sl_tx = 8'h00, sl_sh = 8'h00, sl_rx = 8'h00;
  logic [1:0] sl_mode = 2'b00;
  logic       sl_miso = 1'b0;
  logic       act, lead, prev_act = 1'b0, sclk_prev = 1'b0;
  logic [3:0] ss_prev = 4'hF;
  int         ss_multi = 0, ss_gap = 0;

  assign miso = sl_miso;

  always @(posedge clk) begin
    #1;
    act = (ss_n != 4'hF);
    if ($countones(~ss_n) > 1) ss_multi++;
    if (act && prev_act && ss_n != ss_prev) ss_gap++;
    if (act && !prev_act) begin
      sl_rx = 8'h00;
      if (sl_mode[0]) begin
        sl_sh   = sl_tx;
        sl_miso = 1'b0;
      end else begin
        sl_miso = sl_tx[7];
        sl_sh   = {sl_tx[6:0], 1'b0};
      end
    end else if (act && sclk != sclk_prev) begin
      lead = (sclk_prev == sl_mode[1]);
      if (lead != sl_mode[0]) begin
        sl_rx = {sl_rx[6:0], mosi};
      end else begin
        sl_miso = sl_sh[7];
        sl_sh   = {sl_sh[6:0], 1'b0};
      end
    end
    ss_prev   = ss_n;
    prev_act  = act;
    sclk_prev = sclk;
  end

  int         lat, w, q;
  logic [7:0] rd;
  logic       isc;
  logic [3:0] dn;
  logic [1:0] t2_mode [3] = '{2'b01, 2'b10, 2'b11};
  logic [7:0] t2_slv  [3] = '{8'h3C, 8'hC6, 8'h69};

  // Starts one transfer from an IDLE cycle and returns in the DONE cycle.
  task automatic xfer(input int idx, input logic [7:0] data, input logic [1:0] mode,
                      input logic [7:0] slv, output int l, output logic [7:0] r,
                      output logic idle_sclk, output logic [3:0] d);
    logic seen;
    @(posedge clk); #1;
    sl_tx = slv;
    sl_mode = mode;
    bus.req_data[idx*8 +: 8] = data;
    bus.req_mode[idx*2 +: 2] = mode;
    bus.req[idx] = 1'b1;
    l = 0;
    seen = 1'b0;
    idle_sclk = 1'b0;
    do begin
      @(posedge clk); #1;
      l++;
      if (!seen && bus.grant != 4'h0) begin
        seen = 1'b1;
        idle_sclk = sclk;
      end
    end while (bus.done == 4'h0 && l < 200);
    r = bus.rdata;
    d = bus.done;
    bus.req[idx] = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.req_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'hF);
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: single requester, mode 00
    xfer(0, 8'hA5, 2'b00, 8'h3C, lat, rd, isc, dn);
    chk("t1_latency", 32'(lat), 32'd75);
    chk("t1_rdata", 32'(rd), 32'h3C);
    chk("t1_mosi_stream", 32'(sl_rx), 32'hA5);
    chk("t1_done", 32'(dn), 32'h1);
    chk("t1_sclk_idle", 32'(isc), 32'd0);
    chk("t1_ss_n_done", 32'(ss_n), 32'hF);
    chk("t1_mosi_done", 32'(mosi), 32'd0);

    // 2: remaining modes on requesters 1..3
    for (int k = 0; k < 3; k++) begin
      xfer(k + 1, 8'h81, t2_mode[k], t2_slv[k], lat, rd, isc, dn);
      chk("t2_latency", 32'(lat), 32'd75);
      chk("t2_rdata", 32'(rd), 32'(t2_slv[k]));
      chk("t2_mosi_stream", 32'(sl_rx), 32'h81);
      chk("t2_sclk_idle", 32'(isc), 32'(t2_mode[k][1]));
      chk("t2_done", 32'(dn), 32'(1 << (k + 1)));
    end
    @(posedge clk); #1;
    chk("t2_sclk_released", 32'(sclk), 32'd0);

    // 3: all four requesting, round-robin from pointer 0
    bus.req_mode = '0;
    for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'(8'h10 + i);
    sl_tx = 8'hE7;
    sl_mode = 2'b00;
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      do begin
        @(posedge clk); #1;
        w++;
      end while (bus.done == 4'h0 && w < 200);
      chk("t3_done_order", 32'(bus.done), 32'(1 << (k % 4)));
      chk("t3_mosi_stream", 32'(sl_rx), 32'(8'h10 + (k % 4)));
      if (k == 4) bus.req = 4'h0;
    end
    chk("t3_rdata", 32'(bus.rdata), 32'hE7);

    // 4: reset in the middle of SHIFT, then a clean transfer
    @(posedge clk); #1;
    sl_tx = 8'h99;
    sl_mode = 2'b00;
    bus.req_data[15:8] = 8'hF0;
    bus.req_mode[3:2] = 2'b00;
    bus.req = 4'b0010;
    repeat (40) @(posedge clk);
    #1;
    chk("t4_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t4_ss_n", 32'(ss_n), 32'hF);
    chk("t4_sclk", 32'(sclk), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_done", 32'(bus.done), 32'h0);
    chk("t4_grant", 32'(bus.grant), 32'h0);
    bus.req = 4'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(2, 8'h3C, 2'b00, 8'hA5, lat, rd, isc, dn);
    chk("t4_latency", 32'(lat), 32'd75);
    chk("t4_rdata", 32'(rd), 32'hA5);
    chk("t4_mosi_stream", 32'(sl_rx), 32'h3C);
    chk("t4_done_owner", 32'(dn), 32'h4);

    // 5: request withdrawn before arbitration decides
    @(posedge clk); #1;
    bus.req = 4'b0100;
    @(posedge clk); #1;
    chk("t5_arb_busy", 32'(bus.busy), 32'd1);
    bus.req = 4'h0;
    q = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.grant != 4'h0 || ss_n != 4'hF || bus.done != 4'h0) q++;
    end
    chk("t5_quiet", 32'(q), 32'd0);
    chk("t5_idle", 32'(bus.busy), 32'd0);

`ifdef SPI_LOOPBACK_EN
    // 6: internal loopback ignores miso
    loopback = 1'b1;
    xfer(0, 8'h5A, 2'b00, 8'hFF, lat, rd, isc, dn);
    chk("t6_loopback_rdata", 32'(rd), 32'h5A);
    chk("t6_latency", 32'(lat), 32'd75);
    loopback = 1'b0;
`endif

    chk("ss_n_one_low", 32'(ss_multi), 32'd0);
    chk("ss_n_gap", 32'(ss_gap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
